// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two master request/response channels plus the data-memory port.
// slave: the arbiter's view; master: the masters and memory side.
interface dmem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_wren;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_wren;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_wren_o;
  logic [DW-1:0] mem_data_i;
  logic [1:0]    owner_o;

  modport slave (
    input  m0_req, m0_wren, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_wren, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr_o, mem_data_o, mem_wren_o, owner_o,
    input  mem_data_i
  );

  modport master (
    output m0_req, m0_wren, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_wren, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr_o, mem_data_o, mem_wren_o, owner_o,
    output mem_data_i
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-master data-memory port arbiter: round-robin with MAX_BURST limit, or strict
// m0 priority when DMEM_ARB_CPU_PRIO_EN is defined. Grant 1 cycle after request; rdata 2 edges after beat.
module dmem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                CLK,
  input  logic                RST,
  dmem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

  state_t state, state_nxt;
  logic   rd_pend, rd_route;

  assign bus.owner_o = state;

  // Grant and memory drive follow the owner's live request combinationally.
  always_comb begin
    bus.m0_gnt     = 1'b0;
    bus.m1_gnt     = 1'b0;
    bus.mem_addr_o = '0;
    bus.mem_data_o = '0;
    bus.mem_wren_o = 1'b0;
    case (state)
      OWN0: begin
        bus.m0_gnt = bus.m0_req;
        if (bus.m0_req) begin
          bus.mem_addr_o = bus.m0_addr;
          bus.mem_data_o = bus.m0_wdata;
          bus.mem_wren_o = bus.m0_wren;
        end
      end
      OWN1: begin
        bus.m1_gnt = bus.m1_req;
        if (bus.m1_req) begin
          bus.mem_addr_o = bus.m1_addr;
          bus.mem_data_o = bus.m1_wdata;
          bus.mem_wren_o = bus.m1_wren;
        end
      end
      default: ;
    endcase
  end

`ifdef DMEM_ARB_CPU_PRIO_EN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.m0_req)      state_nxt = OWN0;
        else if (bus.m1_req) state_nxt = OWN1;
      end
      OWN0: if (!bus.m0_req) state_nxt = bus.m1_req ? OWN1 : IDLE;
      OWN1: begin
        if (bus.m0_req)       state_nxt = OWN0;
        else if (!bus.m1_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end
`else
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  logic          last_owner, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          cur_req, oth_req;
  state_t        oth_state;

  always_comb begin
    state_nxt = state;
    last_nxt  = last_owner;
    cnt_nxt   = cnt;
    cur_req   = (state == OWN1) ? bus.m1_req : bus.m0_req;
    oth_req   = (state == OWN1) ? bus.m0_req : bus.m1_req;
    oth_state = (state == OWN1) ? OWN0 : OWN1;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (bus.m0_req && (!bus.m1_req || last_owner)) state_nxt = OWN0;
        else if (bus.m1_req)                           state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        // A beat is accepted whenever cur_req is high, so cnt==CNT_MAX here is the final allowed beat.
        if (!cur_req || (oth_req && cnt == CNT_MAX)) begin
          state_nxt = oth_req ? oth_state : IDLE;
          cnt_nxt   = '0;
          last_nxt  = (state == OWN1);
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_nxt;
      cnt        <= cnt_nxt;
    end
  end
`endif

  // Route is captured with the beat so an owner switch cannot misdirect returning data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_pend       <= 1'b0;
      rd_route      <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rdata  <= '0;
    end else begin
      rd_pend       <= (bus.m0_gnt && !bus.m0_wren) || (bus.m1_gnt && !bus.m1_wren);
      rd_route      <= bus.m1_gnt;
      bus.m0_rvalid <= rd_pend && !rd_route;
      bus.m1_rvalid <= rd_pend && rd_route;
      if (rd_pend && !rd_route) bus.m0_rdata <= bus.mem_data_i;
      if (rd_pend && rd_route)  bus.m1_rdata <= bus.mem_data_i;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: single-port access, writes, arbitration streams,
// in-flight read routing across switches, and asynchronous reset.
module tb_dmem_port_arbiter;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n0, n1, ko, idx;
  logic [1:0]  exp_own, old_own;
  logic [31:0] exp_addr;

  always #5 CLK = ~CLK;

  dmem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_port_arbiter #(.AW(32), .DW(32), .MAX_BURST(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  // Synchronous-read memory: data for the address present at an edge appears after that edge.
  always @(posedge CLK) bus.mem_data_i <= bus.mem_addr_o ^ 32'h5A5A_0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.m0_req = 0; bus.m0_wren = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_wren = 0; bus.m1_addr = '0; bus.m1_wdata = '0;

    // Reset state
    #2;
    check("rst_owner", bus.owner_o, 2'b00);
    check("rst_m0_gnt", bus.m0_gnt, 1'b0);
    check("rst_m1_gnt", bus.m1_gnt, 1'b0);
    check("rst_m0_rvalid", bus.m0_rvalid, 1'b0);
    check("rst_m1_rvalid", bus.m1_rvalid, 1'b0);
    check("rst_m0_rdata", bus.m0_rdata, 32'h0);
    check("rst_mem_wren", bus.mem_wren_o, 1'b0);
    check("rst_mem_addr", bus.mem_addr_o, 32'h0);
    check("rst_mem_data", bus.mem_data_o, 32'h0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;

    // Single m0 read of 0x10
    bus.m0_req = 1; bus.m0_wren = 0; bus.m0_addr = 32'h10;
    #1;
    check("t1_idle_owner", bus.owner_o, 2'b00);
    check("t1_idle_gnt", bus.m0_gnt, 1'b0);
    tick();
    check("t1_owner", bus.owner_o, 2'b01);
    check("t1_gnt", bus.m0_gnt, 1'b1);
    check("t1_mem_addr", bus.mem_addr_o, 32'h10);
    check("t1_mem_wren", bus.mem_wren_o, 1'b0);
    tick();
    bus.m0_req = 0;
    #1;
    check("t1_gnt_drop", bus.m0_gnt, 1'b0);
    check("t1_rvalid_early", bus.m0_rvalid, 1'b0);
    tick();
    check("t1_owner_end", bus.owner_o, 2'b00);
    check("t1_rvalid", bus.m0_rvalid, 1'b1);
    check("t1_rdata", bus.m0_rdata, 32'h5A5A_0010);
    tick();
    check("t1_rvalid_one", bus.m0_rvalid, 1'b0);

    // m1 write, m0 idle
    bus.m1_req = 1; bus.m1_wren = 1; bus.m1_addr = 32'h0007_0000; bus.m1_wdata = 32'hA5;
    #1;
    check("t3_idle_gnt", bus.m1_gnt, 1'b0);
    tick();
    check("t3_owner", bus.owner_o, 2'b10);
    check("t3_gnt", bus.m1_gnt, 1'b1);
    check("t3_m0_gnt", bus.m0_gnt, 1'b0);
    check("t3_mem_wren", bus.mem_wren_o, 1'b1);
    check("t3_mem_addr", bus.mem_addr_o, 32'h0007_0000);
    check("t3_mem_data", bus.mem_data_o, 32'hA5);
    tick();
    bus.m1_req = 0; bus.m1_wren = 0;
    #1;
    check("t3_wren_one", bus.mem_wren_o, 1'b0);
    check("t3_no_rvalid_a", bus.m1_rvalid, 1'b0);
    tick();
    check("t3_no_rvalid_b", bus.m1_rvalid, 1'b0);
    check("t3_owner_end", bus.owner_o, 2'b00);
    check("t3_m0_gnt_end", bus.m0_gnt, 1'b0);

`ifdef DMEM_ARB_CPU_PRIO_EN
    // m1 streams; m0 preempts and then releases
    bus.m1_req = 1; bus.m1_wren = 0; bus.m1_addr = 32'h200;
    tick();
    check("t6_owner_m1", bus.owner_o, 2'b10);
    check("t6_m1_gnt", bus.m1_gnt, 1'b1);
    tick();
    bus.m0_req = 1; bus.m0_wren = 0; bus.m0_addr = 32'h300;
    #1;
    check("t6_pre_owner", bus.owner_o, 2'b10);
    check("t6_pre_m0_gnt", bus.m0_gnt, 1'b0);
    check("t6_pre_m1_gnt", bus.m1_gnt, 1'b1);
    tick();
    check("t6_owner_m0", bus.owner_o, 2'b01);
    check("t6_m0_gnt", bus.m0_gnt, 1'b1);
    check("t6_m1_wait", bus.m1_gnt, 1'b0);
    check("t6_m1_rdata", bus.m1_rdata, 32'h5A5A_0200);
    tick();
    check("t6_m0_hold", bus.owner_o, 2'b01);
    bus.m0_req = 0;
    #1;
    check("t6_m0_drop_gnt", bus.m0_gnt, 1'b0);
    tick();
    check("t6_resume_owner", bus.owner_o, 2'b10);
    check("t6_resume_gnt", bus.m1_gnt, 1'b1);
    check("t6_m0_rdata", bus.m0_rdata, 32'h5A5A_0300);
    bus.m1_req = 0;
    repeat (3) tick();
`else
    // Both masters stream reads: 16-beat alternating bursts, routing checked across switches
    n0 = 0; n1 = 0;
    bus.m0_req = 1; bus.m0_wren = 0; bus.m0_addr = 32'h1000;
    bus.m1_req = 1; bus.m1_wren = 0; bus.m1_addr = 32'h2000;
    #1;
    check("t2_idle_owner", bus.owner_o, 2'b00);
    tick();
    for (int k = 0; k < 64; k++) begin
      bus.m0_addr = 32'h1000 + 32'(4 * n0);
      bus.m1_addr = 32'h2000 + 32'(4 * n1);
      #1;
      exp_own = (((k / 16) % 2) == 0) ? 2'b01 : 2'b10;
      check($sformatf("t2_owner_%0d", k), bus.owner_o, exp_own);
      check($sformatf("t2_m0_gnt_%0d", k), bus.m0_gnt, exp_own == 2'b01);
      check($sformatf("t2_m1_gnt_%0d", k), bus.m1_gnt, exp_own == 2'b10);
      if (k < 2) begin
        check($sformatf("t2_m0_rv_%0d", k), bus.m0_rvalid, 1'b0);
        check($sformatf("t2_m1_rv_%0d", k), bus.m1_rvalid, 1'b0);
      end else begin
        ko = k - 2;
        old_own = (((ko / 16) % 2) == 0) ? 2'b01 : 2'b10;
        idx = (ko / 32) * 16 + (ko % 16);
        exp_addr = ((old_own == 2'b01) ? 32'h1000 : 32'h2000) + 32'(4 * idx);
        check($sformatf("t2_m0_rv_%0d", k), bus.m0_rvalid, old_own == 2'b01);
        check($sformatf("t2_m1_rv_%0d", k), bus.m1_rvalid, old_own == 2'b10);
        if (old_own == 2'b01)
          check($sformatf("t2_m0_rd_%0d", k), bus.m0_rdata, exp_addr ^ 32'h5A5A_0000);
        else
          check($sformatf("t2_m1_rd_%0d", k), bus.m1_rdata, exp_addr ^ 32'h5A5A_0000);
      end
      if (bus.m0_gnt) n0++;
      if (bus.m1_gnt) n1++;
      tick();
    end
    bus.m0_req = 0; bus.m1_req = 0;
    repeat (3) tick();
`endif

    // Async reset with a read in flight
    bus.m0_req = 1; bus.m0_wren = 0; bus.m0_addr = 32'h40;
    tick();
    check("t5_owner", bus.owner_o, 2'b01);
    tick();
    bus.m1_req = 1; bus.m1_wren = 0; bus.m1_addr = 32'h80;
    RST = 1'b0;
    #1;
    check("t5_rst_owner", bus.owner_o, 2'b00);
    check("t5_rst_m0_gnt", bus.m0_gnt, 1'b0);
    check("t5_rst_m1_gnt", bus.m1_gnt, 1'b0);
    check("t5_rst_mem_addr", bus.mem_addr_o, 32'h0);
    check("t5_rst_mem_wren", bus.mem_wren_o, 1'b0);
    check("t5_rst_m0_rdata", bus.m0_rdata, 32'h0);
    check("t5_rst_m1_rdata", bus.m1_rdata, 32'h0);
    bus.m0_req = 0; bus.m1_req = 0;
    tick();
    RST = 1'b1;
    tick();
    check("t5_no_rv_m0", bus.m0_rvalid, 1'b0);
    check("t5_no_rv_m1", bus.m1_rvalid, 1'b0);
    bus.m0_req = 1; bus.m1_req = 1;
    #1;
    check("t5_arb_idle", bus.owner_o, 2'b00);
    tick();
    check("t5_arb_owner", bus.owner_o, 2'b01);
    check("t5_arb_m0_gnt", bus.m0_gnt, 1'b1);
    check("t5_arb_m1_gnt", bus.m1_gnt, 1'b0);
    bus.m0_req = 0; bus.m1_req = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
